mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage
//  (loads/stores) of the 5-stage core. Sequences one transaction at a time: data has priority, with bounded
//  instruction starvation. Drops fetches flushed by a taken branch/jump. Emits StallF/StallM to the pipeline.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width; byte-enable width is DATA_W/8
//  STARVE_MAX  4   max consecutive data grants while IReq waits; the next grant goes to fetch
// PORTS
//  clk        in   1          clock; all state updates on rising edge
//  reset      in   1          synchronous, active-low reset (0 = reset)
//  IReq       in   1          fetch request; held high with IAddr stable until IValid
//  IAddr      in   ADDR_W     fetch address
//  FlushF     in   1          cancel outstanding/pending fetch (PC redirect)
//  IValid     out  1          fetch complete; IRData valid this cycle only
//  IRData     out  DATA_W     fetched instruction
//  DReq       in   1          data request; held high with DWe/DAddr/DWData/DBe stable until DValid
//  DWe        in   1          1 = store, 0 = load
//  DAddr      in   ADDR_W     data address
//  DWData     in   DATA_W     store data
//  DBe        in   DATA_W/8   store byte enables
//  DValid     out  1          data access complete; DRData valid this cycle for loads
//  DRData     out  DATA_W     load data
//  MemReq     out  1          memory request; held until MemAck
//  MemWe      out  1          memory write enable
//  MemAddr    out  ADDR_W     memory address (registered)
//  MemWData   out  DATA_W     memory write data (registered)
//  MemBe      out  DATA_W/8   memory byte enables (registered)
//  MemAck     in   1          memory completes the request this cycle; MemRData valid
//  MemRData   in   DATA_W     memory read data
//  StallF     out  1          IReq & ~IValid & ~FlushF
//  StallM     out  1          DReq & ~DValid
// BEHAVIOUR
//  FSM states: IDLE, IBUSY, DBUSY.
//  IDLE: grant is decided from IReq/DReq this cycle; MemAddr/MemWData/MemBe/MemWe are registered at the edge.
//   - DReq & (~IReq | starve_cnt < STARVE_MAX) -> DBUSY; latch D fields; if IReq, starve_cnt++, else starve_cnt=0.
//   - else if IReq & ~FlushF -> IBUSY; latch IAddr, MemWe=0, MemBe=all ones, MemWData=0; starve_cnt=0; drop=0.
//   - else stay in IDLE. A fetch with FlushF high in the same cycle is never granted.
//  IBUSY/DBUSY: MemReq=1 (registered, from the cycle after grant); memory fields frozen until MemAck.
//   - MemAck=1 -> IDLE next cycle; MemReq low next cycle.
//   - IValid = IBUSY & MemAck & ~drop & ~FlushF (combinational); IRData = MemRData.
//   - DValid = DBUSY & MemAck (combinational); DRData = MemRData.
//   - FlushF in IBUSY sets drop; the transaction still completes on memory but IValid is suppressed.
//  Latency: the minimum is request at cycle N, MemReq at N+1, MemAck at N+1, Valid at N+1.
//   After Valid at cycle K, the first new grant is decided at K+1. A Req sampled high at K+1 is a new request.
//  MemAck in IDLE is ignored. Outputs IRData/DRData are undefined when the matching Valid is low.
//  Requests never preempt a busy transaction. Only the IDLE decision uses priority.
//  Reset (reset=0 at an edge, including mid-transaction): state IDLE, MemReq=0, MemWe=0, MemAddr=0,
//   MemWData=0, MemBe=0, starve_cnt=0, drop=0. An in-flight transaction is abandoned; the memory shares this reset.
//   IValid/DValid are 0 throughout reset; StallF/StallM follow their equations.
//  starve_cnt saturates at STARVE_MAX and is wide enough to hold STARVE_MAX.
// TESTING
//  T1 fetch only: IReq=1,IAddr=0x100; MemAck one cycle after MemReq with MemRData=0x00500093
//     -> MemAddr=0x100, MemWe=0; IValid=1 with IRData=0x00500093 in the ack cycle; StallF=0 on that cycle.
//  T2 store: DReq=1,DWe=1,DAddr=0x2004,DWData=0xDEADBEEF,DBe=4'b0011
//     -> MemReq with these fields and MemWe=1; DValid on ack; no IValid.
//  T3 contention: IReq and DReq held continuously, single-cycle acks, STARVE_MAX=4
//     -> grant order D,D,D,D,I,D,D,D,D,I; StallF high until each IValid.
//  T4 flush: fetch of 0x120 granted, FlushF pulsed during IBUSY, MemAck 3 cycles later
//     -> IValid stays 0; next grant at the cycle after the ack; a pending DReq is serviced next.
//  T5 reset mid-op: DBUSY with MemReq=1, reset=0 for 1 cycle
//     -> next cycle state IDLE, MemReq=0, all Mem* regs 0; a MemAck arriving then is ignored (DValid=0).
//  T6 back-to-back loads: DReq kept high across two addresses 0x10,0x14
//     -> exactly two memory transactions, DValid pulses once per ack, with no duplicate issue.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and the
// load/store stage: data first, with a bounded number of data wins over a waiting fetch.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    // fetch stage
    input  logic                IReq,
    input  logic [ADDR_W-1:0]   IAddr,
    input  logic                FlushF,
    output logic                IValid,
    output logic [DATA_W-1:0]   IRData,
    // memory stage
    input  logic                DReq,
    input  logic                DWe,
    input  logic [ADDR_W-1:0]   DAddr,
    input  logic [DATA_W-1:0]   DWData,
    input  logic [DATA_W/8-1:0] DBe,
    output logic                DValid,
    output logic [DATA_W-1:0]   DRData,
    // memory port
    output logic                MemReq,
    output logic                MemWe,
    output logic [ADDR_W-1:0]   MemAddr,
    output logic [DATA_W-1:0]   MemWData,
    output logic [DATA_W/8-1:0] MemBe,
    input  logic                MemAck,
    input  logic [DATA_W-1:0]   MemRData,
    // pipeline stalls
    output logic                StallF,
    output logic                StallM
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] IBUSY = 2'd1;
    localparam logic [1:0] DBUSY = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] starveCnt;
    logic             drop;
    logic             dataWins;
    logic             fetchWins;

    // Data wins unless the fetch has already been passed over STARVE_MAX times in a row.
    assign dataWins  = DReq & (~IReq | (starveCnt < STARVE_LIM));
    assign fetchWins = ~dataWins & IReq & ~FlushF;

    // NOTE: all state, including the memory-port registers, uses non-blocking
    // assignments and is cleared by the synchronous reset so an abandoned
    // transaction leaves nothing stale on the memory port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            MemReq    <= 1'b0;
            MemWe     <= 1'b0;
            MemAddr   <= '0;
            MemWData  <= '0;
            MemBe     <= '0;
            starveCnt <= '0;
            drop      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dataWins) begin
                        state    <= DBUSY;
                        MemReq   <= 1'b1;
                        MemWe    <= DWe;
                        MemAddr  <= DAddr;
                        MemWData <= DWData;
                        MemBe    <= DBe;
                        if (IReq)
                            starveCnt <= (starveCnt == STARVE_LIM) ? starveCnt
                                                                   : starveCnt + 1'b1;
                        else
                            starveCnt <= '0;
                    end else if (fetchWins) begin
                        state     <= IBUSY;
                        MemReq    <= 1'b1;
                        MemWe     <= 1'b0;
                        MemAddr   <= IAddr;
                        MemWData  <= '0;
                        MemBe     <= {BE_W{1'b1}};
                        starveCnt <= '0;
                        drop      <= 1'b0;
                    end
                end

                IBUSY: begin
                    // A redirect cannot cancel the memory access, only its result.
                    if (FlushF)
                        drop <= 1'b1;
                    if (MemAck) begin
                        state  <= IDLE;
                        MemReq <= 1'b0;
                    end
                end

                DBUSY: begin
                    if (MemAck) begin
                        state  <= IDLE;
                        MemReq <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    MemReq <= 1'b0;
                end
            endcase
        end
    end

    // Completion strobes are forced low while reset is held, even if the
    // state register has not yet been cleared by an edge.
    assign IValid = reset & (state == IBUSY) & MemAck & ~drop & ~FlushF;
    assign DValid = reset & (state == DBUSY) & MemAck;
    assign IRData = MemRData;
    assign DRData = MemRData;

    assign StallF = IReq & ~IValid & ~FlushF;
    assign StallM = DReq & ~DValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, starvation bound, flush,
// mid-transaction reset and back-to-back loads.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              IReq, FlushF, DReq, DWe, MemAck;
    logic [ADDR_W-1:0] IAddr, DAddr;
    logic [DATA_W-1:0] DWData, MemRData;
    logic [3:0]        DBe;
    logic              IValid, DValid, MemReq, MemWe, StallF, StallM;
    logic [DATA_W-1:0] IRData, DRData, MemWData;
    logic [ADDR_W-1:0] MemAddr;
    logic [3:0]        MemBe;

    int nCmp = 0;
    int nErr = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .FlushF(FlushF), .IValid(IValid), .IRData(IRData),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DBe(DBe),
        .DValid(DValid), .DRData(DRData),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemBe(MemBe), .MemAck(MemAck), .MemRData(MemRData),
        .StallF(StallF), .StallM(StallM)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; IReq = 1'b1; IAddr = 32'h0; FlushF = 1'b0;
        DReq = 1'b0; DWe = 1'b0; DAddr = '0; DWData = '0; DBe = '0;
        MemAck = 1'b0; MemRData = '0;
        cyc(); cyc();
        settle();
        nCmp++; if (MemReq !== 1'b0) begin nErr++; $display("FAIL reset_memreq: got %0h want 0", MemReq); end
        nCmp++; if (MemWe !== 1'b0) begin nErr++; $display("FAIL reset_memwe: got %0h want 0", MemWe); end
        nCmp++; if (MemAddr !== 32'h0) begin nErr++; $display("FAIL reset_memaddr: got %h want 0", MemAddr); end
        nCmp++; if (MemWData !== 32'h0) begin nErr++; $display("FAIL reset_memwdata: got %h want 0", MemWData); end
        nCmp++; if (MemBe !== 4'h0) begin nErr++; $display("FAIL reset_membe: got %h want 0", MemBe); end
        nCmp++; if (StallF !== 1'b1) begin nErr++; $display("FAIL reset_stallf: got %0h want 1", StallF); end
        nCmp++; if (IValid !== 1'b0 || DValid !== 1'b0) begin nErr++; $display("FAIL reset_valid: got I=%0h D=%0h want 0 0", IValid, DValid); end
        cyc();
        IReq = 1'b0; reset = 1'b1;
    endtask

    task automatic test_fetch();
        cyc();
        IReq = 1'b1; IAddr = 32'h100;
        settle();
        nCmp++; if (StallF !== 1'b1) begin nErr++; $display("FAIL fetch_stall_wait: got %0h want 1", StallF); end
        cyc();
        MemAck = 1'b1; MemRData = 32'h00500093;
        settle();
        nCmp++; if (MemReq !== 1'b1) begin nErr++; $display("FAIL fetch_memreq: got %0h want 1", MemReq); end
        nCmp++; if (MemAddr !== 32'h100) begin nErr++; $display("FAIL fetch_memaddr: got %h want 00000100", MemAddr); end
        nCmp++; if (MemWe !== 1'b0) begin nErr++; $display("FAIL fetch_memwe: got %0h want 0", MemWe); end
        nCmp++; if (MemBe !== 4'hF) begin nErr++; $display("FAIL fetch_membe: got %h want f", MemBe); end
        nCmp++; if (IValid !== 1'b1) begin nErr++; $display("FAIL fetch_ivalid: got %0h want 1", IValid); end
        nCmp++; if (IRData !== 32'h00500093) begin nErr++; $display("FAIL fetch_irdata: got %h want 00500093", IRData); end
        nCmp++; if (StallF !== 1'b0) begin nErr++; $display("FAIL fetch_stall_ack: got %0h want 0", StallF); end
        nCmp++; if (DValid !== 1'b0) begin nErr++; $display("FAIL fetch_dvalid: got %0h want 0", DValid); end
        cyc();
        IReq = 1'b0; MemAck = 1'b0;
        settle();
        nCmp++; if (MemReq !== 1'b0) begin nErr++; $display("FAIL fetch_memreq_drop: got %0h want 0", MemReq); end
    endtask

    task automatic test_store();
        DReq = 1'b1; DWe = 1'b1; DAddr = 32'h2004; DWData = 32'hDEADBEEF; DBe = 4'b0011;
        cyc();
        settle();
        nCmp++; if (MemReq !== 1'b1) begin nErr++; $display("FAIL store_memreq: got %0h want 1", MemReq); end
        nCmp++; if (MemWe !== 1'b1) begin nErr++; $display("FAIL store_memwe: got %0h want 1", MemWe); end
        nCmp++; if (MemAddr !== 32'h2004) begin nErr++; $display("FAIL store_memaddr: got %h want 00002004", MemAddr); end
        nCmp++; if (MemWData !== 32'hDEADBEEF) begin nErr++; $display("FAIL store_memwdata: got %h want deadbeef", MemWData); end
        nCmp++; if (MemBe !== 4'b0011) begin nErr++; $display("FAIL store_membe: got %b want 0011", MemBe); end
        nCmp++; if (StallM !== 1'b1 || DValid !== 1'b0) begin nErr++; $display("FAIL store_wait: got stall=%0h dvalid=%0h want 1 0", StallM, DValid); end
        cyc();
        MemAck = 1'b1; MemRData = 32'h0;
        settle();
        nCmp++; if (DValid !== 1'b1) begin nErr++; $display("FAIL store_dvalid: got %0h want 1", DValid); end
        nCmp++; if (IValid !== 1'b0) begin nErr++; $display("FAIL store_ivalid: got %0h want 0", IValid); end
        nCmp++; if (StallM !== 1'b0) begin nErr++; $display("FAIL store_stall_ack: got %0h want 0", StallM); end
        cyc();
        DReq = 1'b0; DWe = 1'b0; MemAck = 1'b0;
        settle();
        nCmp++; if (MemReq !== 1'b0) begin nErr++; $display("FAIL store_memreq_drop: got %0h want 0", MemReq); end
    endtask

    task automatic test_contention();
        logic [9:0] gotIsFetch;
        logic [9:0] wantIsFetch;
        int grants;
        wantIsFetch = 10'b10000_10000;  // grants 4 and 9 go to fetch
        gotIsFetch  = '0;
        grants      = 0;
        IReq = 1'b1; IAddr = 32'h300; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h400;
        for (int c = 0; c < 40 && grants < 10; c++) begin
            cyc();
            MemAck = MemReq;
            MemRData = 32'h0000_0C0C;
            settle();
            nCmp++; if (StallF !== ~IValid) begin nErr++; $display("FAIL contention_stallf c%0d: got %0h want %0h", c, StallF, ~IValid); end
            if (IValid || DValid) begin
                gotIsFetch[grants] = IValid;
                grants++;
            end
        end
        IReq = 1'b0; DReq = 1'b0;
        nCmp++; if (grants !== 10) begin nErr++; $display("FAIL contention_count: got %0d want 10", grants); end
        nCmp++; if (gotIsFetch !== wantIsFetch) begin nErr++; $display("FAIL contention_order: got %b want %b", gotIsFetch, wantIsFetch); end
        cyc();
        MemAck = 1'b0;
    endtask

    task automatic test_flush();
        cyc();
        IReq = 1'b1; IAddr = 32'h120;
        cyc();
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h500;
        FlushF = 1'b1;
        settle();
        nCmp++; if (MemReq !== 1'b1 || MemAddr !== 32'h120) begin nErr++; $display("FAIL flush_grant: got req=%0h addr=%h want 1 00000120", MemReq, MemAddr); end
        nCmp++; if (StallF !== 1'b0) begin nErr++; $display("FAIL flush_stallf: got %0h want 0", StallF); end
        cyc();
        FlushF = 1'b0; IReq = 1'b0;
        cyc();
        settle();
        nCmp++; if (MemReq !== 1'b1 || MemAddr !== 32'h120) begin nErr++; $display("FAIL flush_hold: got req=%0h addr=%h want 1 00000120", MemReq, MemAddr); end
        cyc();
        MemAck = 1'b1; MemRData = 32'h0BAD0BAD;
        settle();
        nCmp++; if (IValid !== 1'b0) begin nErr++; $display("FAIL flush_ivalid: got %0h want 0", IValid); end
        nCmp++; if (DValid !== 1'b0) begin nErr++; $display("FAIL flush_dvalid_early: got %0h want 0", DValid); end
        cyc();
        MemAck = 1'b0;
        settle();
        nCmp++; if (MemReq !== 1'b0) begin nErr++; $display("FAIL flush_idle: got %0h want 0", MemReq); end
        cyc();
        MemAck = 1'b1; MemRData = 32'h5555AAAA;
        settle();
        nCmp++; if (MemReq !== 1'b1 || MemAddr !== 32'h500 || MemWe !== 1'b0) begin nErr++; $display("FAIL flush_next_d: got req=%0h addr=%h we=%0h want 1 00000500 0", MemReq, MemAddr, MemWe); end
        nCmp++; if (DValid !== 1'b1 || DRData !== 32'h5555AAAA) begin nErr++; $display("FAIL flush_next_dvalid: got %0h %h want 1 5555aaaa", DValid, DRData); end
        cyc();
        DReq = 1'b0; MemAck = 1'b0;
    endtask

    task automatic test_reset_mid();
        DReq = 1'b1; DWe = 1'b1; DAddr = 32'h600; DWData = 32'h12345678; DBe = 4'hF;
        cyc();
        reset = 1'b0; MemAck = 1'b1;
        settle();
        nCmp++; if (MemReq !== 1'b1) begin nErr++; $display("FAIL rstmid_busy: got %0h want 1", MemReq); end
        nCmp++; if (DValid !== 1'b0) begin nErr++; $display("FAIL rstmid_dvalid_in_reset: got %0h want 0", DValid); end
        nCmp++; if (StallM !== 1'b1) begin nErr++; $display("FAIL rstmid_stallm: got %0h want 1", StallM); end
        cyc();
        reset = 1'b1; DReq = 1'b0; DWe = 1'b0;
        settle();
        nCmp++; if (MemReq !== 1'b0 || MemWe !== 1'b0) begin nErr++; $display("FAIL rstmid_req: got req=%0h we=%0h want 0 0", MemReq, MemWe); end
        nCmp++; if (MemAddr !== 32'h0 || MemWData !== 32'h0 || MemBe !== 4'h0) begin nErr++; $display("FAIL rstmid_regs: got %h %h %h want 0 0 0", MemAddr, MemWData, MemBe); end
        nCmp++; if (DValid !== 1'b0) begin nErr++; $display("FAIL rstmid_ack_ignored: got %0h want 0", DValid); end
        cyc();
        MemAck = 1'b0;
        settle();
        nCmp++; if (MemReq !== 1'b0) begin nErr++; $display("FAIL rstmid_no_issue: got %0h want 0", MemReq); end
    endtask

    task automatic test_back_to_back();
        int issues, valids;
        logic prevReq;
        logic [31:0] wantData;
        issues = 0; valids = 0; prevReq = 1'b0;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h10;
        for (int c = 0; c < 8; c++) begin
            cyc();
            MemAck = MemReq;
            MemRData = (MemAddr == 32'h10) ? 32'hAAAA0010 : 32'hBBBB0014;
            settle();
            if (MemReq && !prevReq) begin
                nCmp++; if (MemAddr !== ((issues == 0) ? 32'h10 : 32'h14)) begin nErr++; $display("FAIL b2b_addr%0d: got %h want %h", issues, MemAddr, (issues == 0) ? 32'h10 : 32'h14); end
                issues++;
            end
            prevReq = MemReq;
            if (DValid) begin
                wantData = (valids == 0) ? 32'hAAAA0010 : 32'hBBBB0014;
                nCmp++; if (DRData !== wantData) begin nErr++; $display("FAIL b2b_data%0d: got %h want %h", valids, DRData, wantData); end
                valids++;
                if (valids == 1) DAddr = 32'h14;
                else DReq = 1'b0;
            end
        end
        MemAck = 1'b0; DReq = 1'b0;
        nCmp++; if (issues !== 2) begin nErr++; $display("FAIL b2b_issues: got %0d want 2", issues); end
        nCmp++; if (valids !== 2) begin nErr++; $display("FAIL b2b_valids: got %0d want 2", valids); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
